// File: rtl/ub_tile_streamer_if.sv
// ub_tile_streamer_if: write port, tile-read command and lane output bundle
// shared by the unified-buffer streamer and its host.
interface ub_tile_streamer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 2,
  parameter int unsigned ADDR_W = 6
);
  logic                    wr_valid_in;
  logic [ADDR_W-1:0]       wr_addr_in;
  logic [LANES*DATA_W-1:0] wr_data_in;
  logic [LANES-1:0]        wr_mask_in;
  logic                    rd_start_in;
  logic [ADDR_W-1:0]       rd_addr_in;
  logic [ADDR_W-1:0]       rd_rows_in;
  logic                    rd_transpose_in;
  logic                    rd_busy_out;
  logic                    rd_done_out;
  logic [LANES*DATA_W-1:0] rd_data_out;
  logic [LANES-1:0]        rd_valid_out;

  // Host side: issues writes and tile commands, consumes lane data.
  modport master (
    output wr_valid_in, wr_addr_in, wr_data_in, wr_mask_in,
    output rd_start_in, rd_addr_in, rd_rows_in, rd_transpose_in,
    input  rd_busy_out, rd_done_out, rd_data_out, rd_valid_out
  );

  // Streamer side.
  modport slave (
    input  wr_valid_in, wr_addr_in, wr_data_in, wr_mask_in,
    input  rd_start_in, rd_addr_in, rd_rows_in, rd_transpose_in,
    output rd_busy_out, rd_done_out, rd_data_out, rd_valid_out
  );
endinterface

// File: rtl/ub_tile_streamer.sv
// ub_tile_streamer: DEPTH-word scratch memory with masked vector writes and a
// tile read engine streaming rows x LANES tiles (row-major or transposed).
// Optional macro UB_STREAM_SKEW_EN: delay lane j by j cycles (systolic skew).
module ub_tile_streamer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 2,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst,
  ub_tile_streamer_if.slave bus
);

`ifdef UB_STREAM_SKEW_EN
  localparam int unsigned DRAIN_LEN = LANES;
`else
  localparam int unsigned DRAIN_LEN = 1;
`endif
  localparam int unsigned DRN_W  = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
  localparam int unsigned LANE_W = LANES * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_base, w_base_nxt;
  logic [ADDR_W-1:0] r_rows, w_rows_nxt;
  logic              r_tr, w_tr_nxt;
  logic [ADDR_W-1:0] r_row, w_row_nxt;
  logic [DRN_W-1:0]  r_drain, w_drain_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              w_issue;

  logic [ADDR_W-1:0] w_rd_addr [LANES];
  logic              r_s1_vld;
  logic [LANE_W-1:0] r_s1_data;
  logic [LANES-1:0]  w_tail_vld;
  logic [LANE_W-1:0] w_tail_data;
  logic [LANES-1:0]  r_valid_out;
  logic [LANE_W-1:0] r_data_out;

  // Masked vector write; lanes wrap around the memory.
  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < LANES; j++) begin
      if (bus.wr_valid_in && bus.wr_mask_in[j]) begin
        r_mem[ADDR_W'(bus.wr_addr_in + ADDR_W'(j))] <= bus.wr_data_in[j*DATA_W +: DATA_W];
      end
    end
  end

  // FSM and command registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_rows  <= '0;
      r_tr    <= 1'b0;
      r_row   <= '0;
      r_drain <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_base_nxt;
      r_rows  <= w_rows_nxt;
      r_tr    <= w_tr_nxt;
      r_row   <= w_row_nxt;
      r_drain <= w_drain_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next state, row/drain counters; done is registered one cycle after DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_rows_nxt  = r_rows;
    w_tr_nxt    = r_tr;
    w_row_nxt   = r_row;
    w_drain_nxt = r_drain;
    w_issue     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.rd_start_in) begin
          w_base_nxt  = bus.rd_addr_in;
          w_rows_nxt  = bus.rd_rows_in;
          w_tr_nxt    = bus.rd_transpose_in;
          w_row_nxt   = '0;
          w_drain_nxt = '0;
          w_state_nxt = (bus.rd_rows_in == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        w_issue = 1'b1;
        if (r_row == ADDR_W'(r_rows - ADDR_W'(1))) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_row_nxt = ADDR_W'(r_row + ADDR_W'(1));
        end
      end
      S_DRAIN: begin
        if (r_drain == DRN_W'(DRAIN_LEN - 1)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_drain_nxt = DRN_W'(r_drain + DRN_W'(1));
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // Element address per lane for the row being fetched.
  always_comb begin
    for (int unsigned j = 0; j < LANES; j++) begin
      if (r_tr) begin
        w_rd_addr[j] = ADDR_W'(r_base + ADDR_W'(j * r_rows) + r_row);
      end else begin
        w_rd_addr[j] = ADDR_W'(r_base + ADDR_W'(r_row * LANES) + ADDR_W'(j));
      end
    end
  end

  // Synchronous memory read; old data wins on a same-cycle write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_data <= '0;
    end else begin
      r_s1_vld <= w_issue;
      for (int unsigned j = 0; j < LANES; j++) begin
        r_s1_data[j*DATA_W +: DATA_W] <= w_issue ? r_mem[w_rd_addr[j]] : '0;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
`ifdef UB_STREAM_SKEW_EN
    if (g == 0) begin : g_direct
      assign w_tail_vld[g]                   = r_s1_vld;
      assign w_tail_data[g*DATA_W +: DATA_W] = r_s1_data[g*DATA_W +: DATA_W];
    end else begin : g_skew
      logic [DATA_W-1:0] r_sk_data [g];
      logic [g-1:0]      r_sk_vld;

      // Delay lane g by g cycles to form the diagonal wavefront.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_sk_vld <= '0;
          for (int i = 0; i < g; i++) r_sk_data[i] <= '0;
        end else begin
          r_sk_vld[0]  <= r_s1_vld;
          r_sk_data[0] <= r_s1_data[g*DATA_W +: DATA_W];
          for (int i = 1; i < g; i++) begin
            r_sk_vld[i]  <= r_sk_vld[i-1];
            r_sk_data[i] <= r_sk_data[i-1];
          end
        end
      end

      assign w_tail_vld[g]                   = r_sk_vld[g-1];
      assign w_tail_data[g*DATA_W +: DATA_W] = r_sk_data[g-1];
    end
`else
    assign w_tail_vld[g]                   = r_s1_vld;
    assign w_tail_data[g*DATA_W +: DATA_W] = r_s1_data[g*DATA_W +: DATA_W];
`endif
  end

  // Output register; idle lanes forced to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid_out <= '0;
      r_data_out  <= '0;
    end else begin
      for (int unsigned j = 0; j < LANES; j++) begin
        r_valid_out[j]                 <= w_tail_vld[j];
        r_data_out[j*DATA_W +: DATA_W] <= w_tail_vld[j] ? w_tail_data[j*DATA_W +: DATA_W] : '0;
      end
    end
  end

  assign bus.rd_busy_out  = r_busy;
  assign bus.rd_done_out  = r_done;
  assign bus.rd_valid_out = r_valid_out;
  assign bus.rd_data_out  = r_data_out;

endmodule

// File: tb/tb_ub_tile_streamer.sv
// tb_ub_tile_streamer: table of tile reads with hand-computed lane data,
// scoreboarded per lane with expected arrival cycle, plus sequences for
// ignored start, rows=0, read/write collision and mid-stream reset.
module tb_ub_tile_streamer;

`ifdef UB_STREAM_SKEW_EN
  localparam int SK = 1;
`else
  localparam int SK = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done = 0;
  bit   mon_en = 1'b1;

  ub_tile_streamer_if #(.DATA_W(16), .LANES(2), .ADDR_W(6)) bus ();

  ub_tile_streamer #(.DATA_W(16), .LANES(2), .DEPTH(64), .ADDR_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          lane;
    int          cyc;
    logic [15:0] d;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [5:0]       a;
    logic [5:0]       r;
    logic             tr;
    logic [3:0][15:0] e0;
    logic [3:0][15:0] e1;
  } vec_t;
  vec_t tbl[4];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Pop/compare one lane against the scoreboard.
  function automatic void lane_chk(input int j);
    int idx = -1;
    logic [15:0] d = bus.rd_data_out[j*16 +: 16];
    foreach (sbq[i]) if (idx < 0 && sbq[i].lane == j) idx = i;
    if (bus.rd_valid_out[j]) begin
      if (idx < 0) begin
        chk($sformatf("lane%0d_unexpected_valid", j), 64'(d), 64'hdead_0000);
      end else begin
        chk($sformatf("lane%0d_data", j), 64'(d), 64'(sbq[idx].d));
        chk($sformatf("lane%0d_cycle", j), 64'(cyc), 64'(sbq[idx].cyc));
        sbq.delete(idx);
      end
    end else begin
      chk($sformatf("lane%0d_zero_when_idle", j), 64'(d), 64'h0);
      if (idx >= 0 && sbq[idx].cyc <= cyc) begin
        chk($sformatf("lane%0d_missing_valid", j), 64'(cyc), 64'(sbq[idx].cyc));
        sbq.delete(idx);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (mon_en) begin
        lane_chk(0);
        lane_chk(1);
      end
      if (bus.rd_done_out) n_done++;
    end
  end

  task automatic wr(input logic [5:0] a, input logic [15:0] d1, input logic [15:0] d0,
                    input logic [1:0] m);
    @(negedge clk);
    bus.wr_valid_in = 1'b1;
    bus.wr_addr_in  = a;
    bus.wr_data_in  = {d1, d0};
    bus.wr_mask_in  = m;
    @(negedge clk);
    bus.wr_valid_in = 1'b0;
    bus.wr_mask_in  = 2'b00;
  endtask

  // Start a tile, push expectations, check done timing and single pulse.
  task automatic run_tile(input logic [5:0] a, input logic [5:0] r, input logic tr,
                          input logic [3:0][15:0] e0, input logic [3:0][15:0] e1,
                          input bit poke, input bit coll);
    int k, kd, nd0, got;
    bit seen;
    @(negedge clk);
    bus.rd_start_in     = 1'b1;
    bus.rd_addr_in      = a;
    bus.rd_rows_in      = r;
    bus.rd_transpose_in = tr;
    k   = cyc + 1;
    nd0 = n_done;
    for (int t = 0; t < int'(r); t++) begin
      sbq.push_back('{lane: 0, cyc: k + 2 + t,      d: e0[t]});
      sbq.push_back('{lane: 1, cyc: k + 2 + t + SK, d: e1[t]});
    end
    @(negedge clk);
    bus.rd_start_in     = 1'b0;
    bus.rd_addr_in      = 6'h2a;
    bus.rd_rows_in      = 6'h3f;
    bus.rd_transpose_in = ~tr;
    chk("busy_after_start", 64'(bus.rd_busy_out), 64'h1);
    kd   = (r == 6'd0) ? k + 1 : k + int'(r) + 2 + SK;
    seen = 1'b0;
    got  = -1;
    for (int i = 0; i < 100; i++) begin
      if (bus.rd_done_out) begin
        seen = 1'b1;
        got  = cyc;
        break;
      end
      bus.rd_start_in = (poke && cyc == k + 1);
      bus.rd_rows_in  = 6'd5;
      if (coll && cyc == k + 1) begin
        bus.wr_valid_in = 1'b1;
        bus.wr_addr_in  = a + 6'd2;
        bus.wr_data_in  = {16'h0000, 16'h7777};
        bus.wr_mask_in  = 2'b01;
      end else begin
        bus.wr_valid_in = 1'b0;
        bus.wr_mask_in  = 2'b00;
      end
      @(negedge clk);
    end
    bus.rd_start_in = 1'b0;
    bus.wr_valid_in = 1'b0;
    chk("done_seen", 64'(seen), 64'h1);
    chk("done_cycle", 64'(got), 64'(kd));
    chk("busy_low_at_done", 64'(bus.rd_busy_out), 64'h0);
    @(negedge clk);
    chk("done_one_cycle", 64'(bus.rd_done_out), 64'h0);
    repeat (SK + 3) @(negedge clk);
    chk("done_pulse_count", 64'(n_done - nd0), 64'h1);
    chk("sb_drained", 64'(sbq.size()), 64'h0);
    sbq.delete();
  endtask

  initial begin
    int k;
    logic [3:0][15:0] c0, c1;

    tbl[0] = '{a: 6'd10, r: 6'd3, tr: 1'b0, e0: {16'h0, 16'd5, 16'd3, 16'd1},
               e1: {16'h0, 16'd6, 16'd4, 16'd2}};
    tbl[1] = '{a: 6'd10, r: 6'd3, tr: 1'b1, e0: {16'h0, 16'd3, 16'd2, 16'd1},
               e1: {16'h0, 16'd6, 16'd5, 16'd4}};
    tbl[2] = '{a: 6'd63, r: 6'd1, tr: 1'b0, e0: {16'h0, 16'h0, 16'h0, 16'hBEEF},
               e1: {16'h0, 16'h0, 16'h0, 16'hCAFE}};
    tbl[3] = '{a: 6'd12, r: 6'd2, tr: 1'b1, e0: {16'h0, 16'h0, 16'd4, 16'd3},
               e1: {16'h0, 16'h0, 16'd6, 16'd5}};

    bus.wr_valid_in = 1'b0; bus.wr_addr_in = '0; bus.wr_data_in = '0; bus.wr_mask_in = '0;
    bus.rd_start_in = 1'b0; bus.rd_addr_in = '0; bus.rd_rows_in = '0; bus.rd_transpose_in = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_busy",  64'(bus.rd_busy_out),  64'h0);
    chk("rst_done",  64'(bus.rd_done_out),  64'h0);
    chk("rst_valid", 64'(bus.rd_valid_out), 64'h0);
    chk("rst_data",  64'(bus.rd_data_out),  64'h0);
    rst = 1'b1;

    wr(6'd10, 16'd2, 16'd1, 2'b11);
    wr(6'd12, 16'd4, 16'd3, 2'b11);
    wr(6'd14, 16'd6, 16'd5, 2'b11);
    for (int i = 0; i < 4; i++)
      wr(6'(20 + 2 * i), 16'(16'h21 + 2 * i), 16'(16'h20 + 2 * i), 2'b11);
    wr(6'd63, 16'hCAFE, 16'hBEEF, 2'b11);
    wr(6'd63, 16'h1234, 16'hBEEF, 2'b01);

    for (int i = 0; i < 4; i++)
      run_tile(tbl[i].a, tbl[i].r, tbl[i].tr, tbl[i].e0, tbl[i].e1, 1'b0, 1'b0);

    // start while busy is ignored
    run_tile(tbl[0].a, tbl[0].r, tbl[0].tr, tbl[0].e0, tbl[0].e1, 1'b1, 1'b0);
    // zero-row tile
    run_tile(6'd5, 6'd0, 1'b0, '0, '0, 1'b0, 1'b0);

    // collision on mem[22] while row 1 is fetched: old data, then new data
    c0 = {16'h26, 16'h24, 16'h22, 16'h20};
    c1 = {16'h27, 16'h25, 16'h23, 16'h21};
    run_tile(6'd20, 6'd4, 1'b0, c0, c1, 1'b0, 1'b1);
    c0[1] = 16'h7777;
    run_tile(6'd20, 6'd4, 1'b0, c0, c1, 1'b0, 1'b0);

    // reset during DRAIN
    mon_en = 1'b0;
    @(negedge clk);
    bus.rd_start_in = 1'b1; bus.rd_addr_in = 6'd10; bus.rd_rows_in = 6'd3; bus.rd_transpose_in = 1'b0;
    k = cyc + 1;
    @(negedge clk);
    bus.rd_start_in = 1'b0;
    for (int i = 0; i < 20 && cyc < k + 3; i++) @(negedge clk);
    chk("pre_reset_cycle", 64'(cyc), 64'(k + 3));
    chk("pre_reset_valid0", 64'(bus.rd_valid_out[0]), 64'h1);
    chk("pre_reset_busy", 64'(bus.rd_busy_out), 64'h1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy",  64'(bus.rd_busy_out),  64'h0);
    chk("mid_rst_done",  64'(bus.rd_done_out),  64'h0);
    chk("mid_rst_valid", 64'(bus.rd_valid_out), 64'h0);
    chk("mid_rst_data",  64'(bus.rd_data_out),  64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy",  64'(bus.rd_busy_out),  64'h0);
    chk("post_rst_valid", 64'(bus.rd_valid_out), 64'h0);
    sbq.delete();
    mon_en = 1'b1;
    run_tile(tbl[0].a, tbl[0].r, tbl[0].tr, tbl[0].e0, tbl[0].e1, 1'b0, 1'b0);
    run_tile(tbl[2].a, tbl[2].r, tbl[2].tr, tbl[2].e0, tbl[2].e1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ub_tile_streamer.md
# ub_tile_streamer

Parametrised unified-buffer read streamer for systolic-array feeding. Holds a DEPTH-word scratch memory written by host/VPU vector writes. On command it streams a rows × LANES tile out on LANES parallel lanes, row-major or transposed, with per-lane systolic skew. It replaces the fixed two-lane bias/input/weight read ports between the UB and the systolic array/VPU.

## Interface
- DATA_W, 16: element width (fixed-point word).
- LANES, 2: number of output lanes (systolic array width), 1..8.
- DEPTH, 64: memory words; power of two.
- ADDR_W, $clog2(DEPTH): address width.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- wr_valid_in  in  1  vector write strobe.
- wr_addr_in  in  ADDR_W  base address of vector write.
- wr_data_in  in  LANES*DATA_W  lane j in bits [j*DATA_W +: DATA_W].
- wr_mask_in  in  LANES  per-lane write enable.
- rd_start_in  in  1  tile read request.
- rd_addr_in  in  ADDR_W  tile base address.
- rd_rows_in  in  ADDR_W  tile row count; 0 is legal.
- rd_transpose_in  in  1  1 = column-major fetch.
- rd_busy_out  out  1  high from accepted start until done.
- rd_done_out  out  1  one-cycle pulse at tile completion.
- rd_data_out  out  LANES*DATA_W  lane data, registered.
- rd_valid_out  out  LANES  per-lane valid, registered.

## Operation
- Vector write: when wr_valid_in is high, lane j with wr_mask_in[j]=1 writes mem[(wr_addr_in+j) mod DEPTH]. Writes are legal at any time, including mid-stream.
- Start is accepted only in IDLE. rd_start_in in any other state is ignored with no side effect. On acceptance, addr, rows and transpose are latched; later input changes have no effect.
- Element address for row t (0..rows-1), lane j, all mod DEPTH:
  - Normal: base + t*LANES + j.
  - Transpose: base + j*rows + t.
- FSM states:
  - IDLE: go to FETCH on start with rows>0. Go to DONE on start with rows=0.
  - FETCH: issue one row per cycle; row counter 0..rows-1. After the last row, go to DRAIN.
  - DRAIN: wait until the highest lane has emitted its last element, then go to DONE.
  - DONE: pulse rd_done_out, then return to IDLE.
- rd_busy_out is high in FETCH, DRAIN and DONE.
- Read/write collision on the same address in the same cycle: read returns old data (read-before-write).
- rd_data_out lane j is 0 whenever rd_valid_out[j] is 0.
- Address arithmetic is ADDR_W-bit unsigned; overflow wraps silently.
- Reset: asynchronous, takes effect immediately, mid-stream included.
  - FSM returns to IDLE.
  - rd_busy_out, rd_done_out, rd_valid_out and rd_data_out all go to 0.
  - Memory contents are not cleared.

## Timing
- Start sampled at edge k. Row t, lane j is presented after edge k+2+t+s(j), where s(j)=j with skew enabled and 0 without.
- Each lane is valid for exactly rows consecutive cycles.
- rd_done_out pulses in the cycle after the last valid of lane LANES-1 (skew) or lane 0 (no skew).
- rows=0: rd_done_out pulses after edge k+1; no valid is ever asserted.
- Back-to-back tiles: the earliest next start is accepted the cycle after rd_done_out, i.e. once rd_busy_out is low.
- The 1-cycle memory read and 1 output register stage are the only latency; there is no backpressure.

## Configuration
- UB_STREAM_SKEW_EN defined: lane j is delayed j cycles through a per-lane shift register, giving the diagonal wavefront the systolic array expects. DRAIN lasts LANES cycles.
- UB_STREAM_SKEW_EN undefined: all lanes are aligned (s(j)=0) and no skew registers are built. DRAIN lasts 1 cycle.

## Test plan
All scenarios use LANES=2, DATA_W=16, DEPTH=64.

- **Row-major, skew on:** write mem[10..15]=1..6, then start addr=10, rows=3, transpose=0. Lane0 gives 1,3,5 after edges k+2..k+4; lane1 gives 2,4,6 after edges k+3..k+5. Done pulses once, after edge k+6.
- **Transpose:** same memory, start addr=10, rows=3, transpose=1. Lane0 gives 1,2,3; lane1 gives 4,5,6, with the same timing as above.
- **Wrap and mask:** write addr=63, data {0xBEEF,0xCAFE}, mask=2'b11. Expect mem[63]=0xBEEF and mem[0]=0xCAFE. Rewrite with mask=2'b01 and new data: mem[0] stays 0xCAFE. Stream addr=63, rows=1 and check lanes give 0xBEEF and 0xCAFE.
- **Ignored start and rows=0:** assert rd_start_in while busy; the stream is unchanged and only one done pulse occurs. A start with rows=0 gives done 2 cycles after start and no valid.
- **Collision:** stream addr=20, rows=4 while writing 0x7777 to the address being fetched that same cycle. The output shows the old value; a following stream shows 0x7777.
- **Reset mid-stream:** drop rst during DRAIN. All outputs are 0 immediately, busy is 0 and the FSM is in IDLE. After reset release, a new stream returns the pre-reset memory data.
